// File: rtl/prbs_gen_multi_if.sv
// ============================================================================
// Module      : prbs_gen_multi_if
// Description : Valid/ready word bus between the PRBS source and its consumer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface prbs_gen_multi_if #(
  parameter int W = 8
);
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

`default_nettype wire

// File: rtl/prbs_gen_multi.sv
// ============================================================================
// Module      : prbs_gen_multi
// Description : W-bit parallel PRBS7/15/23/31 generator with seed load,
//               single-bit error injection and accepted-word counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prbs_gen_multi #(
  parameter int W        = 8,
  parameter int RST_MODE = 0
) (
  input  wire logic          clk,
  input  wire logic          reset,
  input  wire logic          en,
  input  wire logic [1:0]    mode,
  input  wire logic          seed_load,
  input  wire logic [30:0]   seed,
  input  wire logic          inject_err,
  prbs_gen_multi_if.master   out,
  output logic      [31:0]   word_cnt
);

  localparam logic [1:0] RST_SEL = RST_MODE[1:0];

  function automatic logic [30:0] mask_of(input logic [1:0] m);
    logic [30:0] r;
    case (m)
      2'd0:    r = 31'h0000_007F;
      2'd1:    r = 31'h0000_7FFF;
      2'd2:    r = 31'h007F_FFFF;
      default: r = 31'h7FFF_FFFF;
    endcase
    return r;
  endfunction

  localparam logic [30:0] RST_STATE = mask_of(RST_SEL);

  logic [30:0]  lfsr;
  logic [1:0]   cur_mode;
  logic [W-1:0] word_reg;
  logic         valid_reg;
  logic [31:0]  count;

  logic [30:0]  next_lfsr;
  logic [W-1:0] next_word;
  logic [W-1:0] inj_mask;
  logic         fb;
  logic [30:0]  seed_masked;
  logic [30:0]  seed_state;
  logic         transfer;
  logic         load;

  // W Fibonacci steps unrolled; the first generated bit lands in the MSB.
  always_comb begin
    next_lfsr = lfsr;
    next_word = '0;
    fb        = 1'b0;
    for (int i = 0; i < W; i++) begin
      case (cur_mode)
        2'd0:    fb = next_lfsr[6]  ^ next_lfsr[5];
        2'd1:    fb = next_lfsr[14] ^ next_lfsr[13];
        2'd2:    fb = next_lfsr[22] ^ next_lfsr[17];
        default: fb = next_lfsr[30] ^ next_lfsr[27];
      endcase
      next_word[W-1-i] = fb;
      case (cur_mode)
        2'd0:    next_lfsr = {24'd0, next_lfsr[5:0],  fb};
        2'd1:    next_lfsr = {16'd0, next_lfsr[13:0], fb};
        2'd2:    next_lfsr = {8'd0,  next_lfsr[21:0], fb};
        default: next_lfsr = {next_lfsr[29:0], fb};
      endcase
    end
  end

  always_comb begin
    inj_mask    = '0;
    inj_mask[0] = inject_err;
    seed_masked = seed & mask_of(mode);
    // An all-zero seed would lock the LFSR, so substitute all-ones.
    seed_state  = (seed_masked == 31'd0) ? mask_of(mode) : seed_masked;
  end

  assign transfer = valid_reg && out.out_ready;
  assign load     = en && (!valid_reg || out.out_ready) && !seed_load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr      <= RST_STATE;
      cur_mode  <= RST_SEL;
      word_reg  <= '0;
      valid_reg <= 1'b0;
      count     <= 32'd0;
    end else if (seed_load) begin
      lfsr      <= seed_state;
      cur_mode  <= mode;
      valid_reg <= 1'b0;
      count     <= 32'd0;
    end else begin
      if (load) begin
        word_reg  <= next_word ^ inj_mask;
        lfsr      <= next_lfsr;
        valid_reg <= 1'b1;
      end else if (transfer) begin
        valid_reg <= 1'b0;
      end
      if (transfer) begin
        count <= count + 32'd1;
      end
    end
  end

  assign out.out_valid = valid_reg;
  assign out.out_data  = word_reg;
  assign word_cnt      = count;

endmodule

`default_nettype wire

// File: tb/tb_prbs_gen_multi.sv
// ============================================================================
// Module      : tb_prbs_gen_multi
// Description : Scoreboard bench for prbs_gen_multi against a polynomial model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prbs_gen_multi;

  localparam int W = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        seed_load = 1'b0;
  logic [30:0] seed = 31'd0;
  logic        inject_err = 1'b0;
  logic [31:0] word_cnt;

  logic        en1 = 1'b0;
  logic [31:0] word_cnt1;

  prbs_gen_multi_if #(.W(W)) bus ();
  prbs_gen_multi_if #(.W(1)) bus1 ();

  prbs_gen_multi #(.W(W), .RST_MODE(0)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .seed_load(seed_load),
    .seed(seed), .inject_err(inject_err), .out(bus.master), .word_cnt(word_cnt)
  );

  prbs_gen_multi #(.W(1), .RST_MODE(0)) dut1 (
    .clk(clk), .reset(reset), .en(en1), .mode(2'd0), .seed_load(1'b0),
    .seed(31'd0), .inject_err(1'b0), .out(bus1.master), .word_cnt(word_cnt1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: polynomial x^N + x^K + 1 as plain integer arithmetic.
  int poly_n[4] = '{7, 15, 23, 31};
  int poly_k[4] = '{6, 14, 18, 28};
  longint unsigned m_s;
  int              m_mode;
  bit              m_valid;
  logic [31:0]     m_cnt;
  logic [W-1:0]    exp_q[$];

  task automatic check(input string name, input longint unsigned act, input longint unsigned req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic longint unsigned all_ones(input int n);
    return (64'd1 << n) - 64'd1;
  endfunction

  function automatic logic [W-1:0] model_word();
    int n, k;
    longint unsigned b;
    logic [W-1:0] w;
    n = poly_n[m_mode];
    k = poly_k[m_mode];
    w = '0;
    for (int i = 0; i < W; i++) begin
      b   = ((m_s >> (n - 1)) ^ (m_s >> (k - 1))) & 64'd1;
      m_s = ((m_s << 1) | b) & all_ones(n);
      w   = {w[W-2:0], b[0]};
    end
    return w;
  endfunction

  task automatic model_reset();
    m_mode  = 0;
    m_s     = all_ones(7);
    m_valid = 1'b0;
    m_cnt   = 32'd0;
    exp_q.delete();
  endtask

  // Apply one cycle of inputs at the falling edge and predict its effect.
  task automatic drive(input logic e, input logic r, input logic sl,
                       input logic [1:0] md, input logic [30:0] sd, input logic inj);
    logic [W-1:0] w;
    @(negedge clk);
    en = e; bus.out_ready = r; seed_load = sl; mode = md; seed = sd; inject_err = inj;
    if (sl) begin
      m_mode = int'(md);
      m_s    = longint'(sd) & all_ones(poly_n[m_mode]);
      if (m_s == 0) m_s = all_ones(poly_n[m_mode]);
      m_valid = 1'b0;
      m_cnt   = 32'd0;
      exp_q.delete();
    end else if (e && (!m_valid || r)) begin
      w = model_word();
      if (inj) w[0] = ~w[0];
      exp_q.push_back(w);
      m_valid = 1'b1;
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle the DUT presents an accepted word, compare with the queue.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (!reset && bus.out_valid && bus.out_ready && !seed_load) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_word", 64'(bus.out_data), 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("sb_word", 64'(bus.out_data), 64'(e));
          check("sb_word_cnt", 64'(word_cnt), 64'(m_cnt));
          m_cnt = m_cnt + 32'd1;
        end
      end
    end
  end

  bit bits[$];

  initial begin
    bit zero_run;
    bus.out_ready  = 1'b0;
    bus1.out_ready = 1'b1;
    model_reset();

    repeat (3) @(negedge clk);
    check("rst_valid", 64'(bus.out_valid), 0);
    check("rst_data", 64'(bus.out_data), 0);
    check("rst_cnt", 64'(word_cnt), 0);

    // W=1 PRBS7 period: 254 bits must repeat with period 127.
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 300 && bits.size() < 254; c++) begin
      @(negedge clk);
      en1 = 1'b1;
      #1;
      if (bus1.out_valid) bits.push_back(bus1.out_data[0]);
    end
    en1 = 1'b0;
    check("period_bits_collected", 64'(bits.size()), 254);
    if (bits.size() == 254) begin
      for (int i = 0; i < 127; i++) check("period_repeat", 64'(bits[127+i]), 64'(bits[i]));
      zero_run = 1'b0;
      for (int i = 0; i + 7 <= 254; i++) begin
        if ({bits[i], bits[i+1], bits[i+2], bits[i+3], bits[i+4], bits[i+5], bits[i+6]} == 7'd0)
          zero_run = 1'b1;
      end
      check("period_no_zero_state", 64'(zero_run), 0);
    end

    // PRBS7 first word, stall, then injected second word.
    drive(1, 1, 0, 2'd0, 31'd0, 0);
    settle();
    check("first_valid", 64'(bus.out_valid), 1);
    check("first_word", 64'(bus.out_data), 64'h02);
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 2'(i), 31'(i), 0);
      settle();
      check("stall_data", 64'(bus.out_data), 64'h02);
      check("stall_valid", 64'(bus.out_valid), 1);
      check("stall_cnt", 64'(word_cnt), 0);
    end
    drive(1, 1, 0, 2'd3, 31'd0, 1);
    settle();
    check("inject_word", 64'(bus.out_data), 64'h0D);
    check("inject_cnt", 64'(word_cnt), 1);
    drive(1, 1, 0, 2'd0, 31'd0, 0);
    drive(1, 1, 0, 2'd0, 31'd0, 0);

    // Seed load to PRBS31 with an all-zero seed.
    drive(1, 0, 1, 2'd3, 31'd0, 0);
    settle();
    check("seed_valid_drop", 64'(bus.out_valid), 0);
    check("seed_cnt_clear", 64'(word_cnt), 0);
    for (int i = 0; i < 20; i++) drive(1, 1'($urandom_range(0, 2) != 0), 0, 2'($urandom), 31'($urandom), 0);

    // Randomised traffic with occasional reseeding.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 24) == 0)
        drive(1'($urandom), 0, 1, 2'($urandom), ($urandom_range(0, 3) == 0) ? 31'd0 : 31'($urandom), 0);
      else
        drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), 0,
              2'($urandom), 31'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    // Asynchronous reset in the middle of traffic.
    drive(1, 1, 0, 2'd0, 31'd0, 0);
    @(negedge clk);
    #3;
    reset = 1'b1;
    en = 1'b0;
    #1;
    check("midrst_valid", 64'(bus.out_valid), 0);
    check("midrst_data", 64'(bus.out_data), 0);
    check("midrst_cnt", 64'(word_cnt), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    drive(1, 1, 0, 2'd0, 31'd0, 0);
    settle();
    check("restart_word0", 64'(bus.out_data), 64'h02);
    drive(1, 1, 0, 2'd0, 31'd0, 0);
    settle();
    check("restart_word1", 64'(bus.out_data), 64'h0C);
    check("restart_cnt", 64'(word_cnt), 1);

    // Counter wrap: hold a word pending, preset the counter, then accept.
    drive(1, 0, 0, 2'd0, 31'd0, 0);
    @(negedge clk);
    force dut.count = 32'hFFFF_FFFF;
    #1;
    release dut.count;
    m_cnt = 32'hFFFF_FFFF;
    drive(0, 1, 0, 2'd0, 31'd0, 0);
    settle();
    check("wrap_cnt", 64'(word_cnt), 0);
    drive(0, 0, 0, 2'd0, 31'd0, 0);
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
